// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with optional hard-zero register 0,
// optional write-to-read forwarding, and a one-entry-per-cycle sequential clear.
module reg_file_2r1w #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;
    logic              busy_reg, busy_next;
    logic              clr_done_reg, clr_done_next;
    logic              wr_en;

    logic [DATA_W-1:0] regs      [DEPTH];
    logic [DATA_W-1:0] regs_next [DEPTH];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            clr_ptr_reg  <= '0;
            busy_reg     <= 1'b0;
            clr_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_ptr_reg  <= clr_ptr_next;
            busy_reg     <= busy_next;
            clr_done_reg <= clr_done_next;
        end
    end

    // Next-state logic; clr_req is ignored once CLEAR has started
    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next   = CLEAR;
                    clr_ptr_next = '0;
                end
            end
            CLEAR: begin
                clr_ptr_next = clr_ptr_reg + 1'b1;
                if (clr_ptr_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: status flags are registered from the next state
    always_comb begin
        busy_next     = (state_next == CLEAR);
        clr_done_next = (state_reg == CLEAR) && (state_next == IDLE);
        wr_en         = (state_reg == IDLE) && we && !clr_req;
    end

    assign busy     = busy_reg;
    assign clr_done = clr_done_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam bit WRITABLE = !((ZERO_REG != 0) && (gi == 0));
            always_comb begin
                regs_next[gi] = regs[gi];
                if ((state_reg == CLEAR) && (clr_ptr_reg == ADDR_W'(gi))) begin
                    regs_next[gi] = '0;
                end else if (WRITABLE && wr_en && (waddr == ADDR_W'(gi))) begin
                    regs_next[gi] = wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= regs_next[i];
            end
        end
    end

    // Read ports; forwarding never applies to a hard-zero register 0
    logic [ADDR_W-1:0] raddr_p [2];
    logic [DATA_W-1:0] rdata_p [2];
    logic              waddr_zeroed;

    assign raddr_p[0]   = raddr_a;
    assign raddr_p[1]   = raddr_b;
    assign rdata_a      = rdata_p[0];
    assign rdata_b      = rdata_p[1];
    assign waddr_zeroed = (ZERO_REG != 0) && (waddr == '0);

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            always_comb begin
                if ((BYPASS != 0) && wr_en && !waddr_zeroed && (raddr_p[gi] == waddr)) begin
                    rdata_p[gi] = wdata;
                end else if ((ZERO_REG != 0) && (raddr_p[gi] == '0)) begin
                    rdata_p[gi] = '0;
                end else begin
                    rdata_p[gi] = regs[raddr_p[gi]];
                end
            end
        end
    endgenerate

endmodule
